// File: rtl/rc_sched_pkg.sv
// Shared types and constants for the rc_statistic window scheduler.
// Holds the FSM state encoding, sample/counter widths and default timing constants.
package rc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    FLUSH,
    RUN,
    WAIT_VLD,
    REPORT
  } state_t;

  localparam int SAMPLE_W      = 4;
  localparam int HIT_W         = 8;
  localparam int DEF_WIN_LEN   = 256;
  localparam int DEF_FLUSH_CYC = 2;
  localparam int DEF_TMO_CYC   = 16;

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rc_stat_sched_if.sv
// Engine-side and result-side signals of the scheduler.
// master = scheduler, slave = engine + result consumer.
interface rc_stat_sched_if
  import rc_sched_pkg::*;
#(
  parameter int NUM_CH = 3
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                eng_rst_n;
  logic [SAMPLE_W-1:0] eng_a;
  logic [SAMPLE_W-1:0] eng_b;
  logic [SAMPLE_W-1:0] eng_c;
  logic                eng_vld;
  logic                eng_f;
  logic                res_vld;
  logic                res_rdy;
  logic [IW-1:0]       res_ch;
  logic                res_f;
  logic                res_err;

  modport master (
    output eng_rst_n, eng_a, eng_b, eng_c, res_vld, res_ch, res_f, res_err,
    input  eng_vld, eng_f, res_rdy
  );

  modport slave (
    input  eng_rst_n, eng_a, eng_b, eng_c, res_vld, res_ch, res_f, res_err,
    output eng_vld, eng_f, res_rdy
  );

endinterface

// File: rtl/rc_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr+1; combinational grant.
// Pointer moves to the granted channel when en is high; reset pointer NUM_CH-1 so channel 0 wins first.
module rc_rr_arbiter #(
  parameter int NUM_CH = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CH-1:0]                       req,
  input  logic                                    en,
  output logic [NUM_CH-1:0]                       gnt,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] gnt_idx
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  // Walk candidates farthest-first so the nearest requester after ptr is written last.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_CH)) cand = cand - (IW+1)'(NUM_CH);
      if (req[cand[IW-1:0]]) gnt_idx = cand[IW-1:0];
    end
    gnt = (|req) ? (NUM_CH'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= IW'(NUM_CH - 1);
    else if (en && |req) ptr <= gnt_idx;
  end

endmodule

// File: rtl/rc_stat_sched.sv
// Time-shares one rc_statistic engine among NUM_CH requesters; ARB to res_vld = 1+FLUSH_CYC+WIN_LEN+1 nominal.
// Result held until res_rdy, no new grant meanwhile; RC_STAT_SCHED_HIT_CNT_EN adds per-channel F=1 counters.
module rc_stat_sched
  import rc_sched_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int WIN_LEN   = DEF_WIN_LEN,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC,
  parameter int TMO_CYC   = DEF_TMO_CYC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req,
  input  logic [SAMPLE_W*NUM_CH-1:0] ch_a,
  input  logic [SAMPLE_W*NUM_CH-1:0] ch_b,
  input  logic [SAMPLE_W*NUM_CH-1:0] ch_c,
  output logic [NUM_CH-1:0]          gnt,
  output logic [HIT_W*NUM_CH-1:0]    hit_cnt,
  rc_stat_sched_if.master            bus
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(WIN_LEN);
  localparam int TW = $clog2(TMO_CYC);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic [NUM_CH-1:0] gnt_nxt, arb_gnt;
  logic [IW-1:0]     cur_ch, cur_ch_nxt, arb_idx;
  logic              res_f_q, res_f_nxt;
  logic              res_err_q, res_err_nxt;
  logic              arb_en;
  logic              drive;

  rc_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tmr       <= '0;
      gnt       <= '0;
      cur_ch    <= '0;
      res_f_q   <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tmr       <= tmr_nxt;
      gnt       <= gnt_nxt;
      cur_ch    <= cur_ch_nxt;
      res_f_q   <= res_f_nxt;
      res_err_q <= res_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tmr_nxt     = tmr;
    gnt_nxt     = gnt;
    cur_ch_nxt  = cur_ch;
    res_f_nxt   = res_f_q;
    res_err_nxt = res_err_q;
    arb_en      = 1'b0;
    case (state)
      IDLE: if (|req) state_nxt = ARB;
      ARB: begin
        if (|req) begin
          arb_en     = 1'b1;
          gnt_nxt    = arb_gnt;
          cur_ch_nxt = arb_idx;
          cnt_nxt    = '0;
          state_nxt  = FLUSH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (cnt == CW'(FLUSH_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        // Engine Vld only counts on the last window cycle; earlier pulses are stale.
        if (cnt == CW'(WIN_LEN - 1)) begin
          tmr_nxt = '0;
          if (bus.eng_vld) begin
            res_f_nxt   = bus.eng_f;
            res_err_nxt = 1'b0;
            state_nxt   = REPORT;
          end else begin
            state_nxt = WAIT_VLD;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_VLD: begin
        if (bus.eng_vld) begin
          res_f_nxt   = bus.eng_f;
          res_err_nxt = 1'b0;
          state_nxt   = REPORT;
        end else if (tmr == TW'(TMO_CYC - 1)) begin
          res_f_nxt   = 1'b0;
          res_err_nxt = 1'b1;
          state_nxt   = REPORT;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      REPORT: begin
        if (bus.res_rdy) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drive         = (state == RUN) || (state == WAIT_VLD);
  assign bus.eng_rst_n = drive || (state == REPORT);
  assign bus.eng_a     = drive ? ch_a[int'(cur_ch)*SAMPLE_W +: SAMPLE_W] : '0;
  assign bus.eng_b     = drive ? ch_b[int'(cur_ch)*SAMPLE_W +: SAMPLE_W] : '0;
  assign bus.eng_c     = drive ? ch_c[int'(cur_ch)*SAMPLE_W +: SAMPLE_W] : '0;
  assign bus.res_vld   = (state == REPORT);
  assign bus.res_ch    = cur_ch;
  assign bus.res_f     = res_f_q;
  assign bus.res_err   = res_err_q;

`ifdef RC_STAT_SCHED_HIT_CNT_EN
  logic             hit_inc;
  logic [HIT_W-1:0] hit_q [NUM_CH];

  assign hit_inc = (state == REPORT) && bus.res_rdy && res_f_q && !res_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) hit_q[i] <= '0;
    end else if (hit_inc) begin
      hit_q[cur_ch] <= sat_inc(hit_q[cur_ch]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
    assign hit_cnt[g*HIT_W +: HIT_W] = hit_q[g];
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_rc_stat_sched.sv
// Bench for rc_stat_sched: engine stub, window-offset reference model, per-cycle compare plus directed checks.
module tb_rc_stat_sched;
  localparam int NUM_CH = 3;
  localparam int W = 256;
  localparam int F = 2;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [11:0] ch_a, ch_b, ch_c;
  logic [2:0]  gnt;
  logic [23:0] hit_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int pat [3] = '{0, 0, 0};
  int mode = 0;   // 0 normal, 1 never Vld, 2 spurious early Vld
  int dly = 0;    // shift of the engine Vld relative to the nominal cycle

  rc_stat_sched_if #(.NUM_CH(NUM_CH)) bus ();

  rc_stat_sched #(.NUM_CH(NUM_CH), .WIN_LEN(W), .FLUSH_CYC(F), .TMO_CYC(T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ch_a    (ch_a),
    .ch_b    (ch_b),
    .ch_c    (ch_c),
    .gnt     (gnt),
    .hit_cnt (hit_cnt),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] nib(input int p, input int cy);
    return (p == 1 || (p == 2 && cy[0])) ? 4'h8 : 4'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      ch_a[i*4 +: 4] = nib(pat[i], cyc);
      ch_b[i*4 +: 4] = nib(pat[i], cyc);
      ch_c[i*4 +: 4] = nib(pat[i], cyc);
    end
  end

  // Engine stub: F = more than half of the first W samples are all-8; Vld W+dly cycles after release.
  int sn = 0, sn1 = 0;
  always @(posedge clk) begin
    if (!bus.eng_rst_n) begin
      sn = 0; sn1 = 0;
      bus.eng_vld <= (mode == 2);
      bus.eng_f   <= (mode == 2);
    end else begin
      sn = sn + 1;
      if (sn <= W && bus.eng_a[3] && bus.eng_b[3] && bus.eng_c[3]) sn1 = sn1 + 1;
      bus.eng_vld <= 1'b0;
      bus.eng_f   <= 1'b0;
      if (mode != 1 && sn == W + dly) begin
        bus.eng_vld <= 1'b1;
        bus.eng_f   <= (sn1 > W/2);
      end
      if (mode == 2 && sn == 10) begin
        bus.eng_vld <= 1'b1;
        bus.eng_f   <= 1'b1;
      end
    end
  end

  // Reference model: position of the current job counted in cycles from its ARB cycle (k=0).
  bit         m_act = 0, m_rep = 0, m_f = 0, m_err = 0, m_found = 0;
  int         m_k = 0, m_ptr = NUM_CH - 1, m_ch = 0, m_arb_cyc = 0, m_rep_cyc = 0;
  logic [7:0] m_hit [3] = '{default: 8'd0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_rep = 0; m_f = 0; m_err = 0; m_k = 0; m_ptr = NUM_CH - 1; m_ch = 0;
      for (int i = 0; i < 3; i++) m_hit[i] = 8'd0;
    end else if (m_rep) begin
      if (bus.res_rdy) begin
        if (m_f && !m_err && m_hit[m_ch] != 8'd255) m_hit[m_ch] = m_hit[m_ch] + 8'd1;
        m_rep = 0; m_act = 0;
      end
    end else if (m_act) begin
      if (m_k == 0) begin
        if (req == 3'b000) m_act = 0;
        else begin
          m_found = 0;
          for (int i = 1; i <= NUM_CH; i++)
            if (!m_found && req[(m_ptr + i) % NUM_CH]) begin
              m_found = 1; m_ch = (m_ptr + i) % NUM_CH;
            end
          m_ptr = m_ch; m_k = 1;
        end
      end else if (bus.eng_vld === 1'b1 && m_k >= F + W) begin
        m_rep = 1; m_f = bus.eng_f; m_err = 0; m_rep_cyc = cyc + 1;
      end else if (m_k == F + W + T) begin
        m_rep = 1; m_f = 0; m_err = 1; m_rep_cyc = cyc + 1;
      end else begin
        m_k = m_k + 1;
      end
    end else if (req != 3'b000) begin
      m_act = 1; m_k = 0; m_arb_cyc = cyc + 1;
    end
  end

  logic [44:0] exp_v, act_v;
  logic [2:0]  e_g;
  logic [3:0]  e_a, e_b, e_c;
  logic [23:0] e_h;
  bit          e_run;
  always @(negedge clk) begin
    if (chk_en) begin
      e_run = m_act && !m_rep && m_k > F;
      e_g = (m_act && m_k >= 1) ? 3'(1 << m_ch) : 3'b000;
      e_a = e_run ? ch_a[m_ch*4 +: 4] : 4'h0;
      e_b = e_run ? ch_b[m_ch*4 +: 4] : 4'h0;
      e_c = e_run ? ch_c[m_ch*4 +: 4] : 4'h0;
`ifdef RC_STAT_SCHED_HIT_CNT_EN
      e_h = {m_hit[2], m_hit[1], m_hit[0]};
`else
      e_h = 24'd0;
`endif
      exp_v = {e_g, m_rep || e_run, e_a, e_b, e_c, m_rep, m_rep ? 2'(m_ch) : 2'd0,
               m_rep & m_f, m_rep & m_err, e_h};
      act_v = {gnt, bus.eng_rst_n, bus.eng_a, bus.eng_b, bus.eng_c, bus.res_vld,
               bus.res_vld ? bus.res_ch : 2'd0, bus.res_vld & bus.res_f,
               bus.res_vld & bus.res_err, hit_cnt};
      n_chk++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle %0d: dut %h model %h", cyc, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_vld(output int c);
    c = -1;
    for (int n = 0; n < 3000 && c < 0; n++) begin
      @(negedge clk);
      if (bus.res_vld === 1'b1) c = cyc;
    end
    if (c < 0) begin
      n_chk++; n_err++;
      $display("FAIL res_vld_timeout: got none expected res_vld within 3000 cycles");
    end
  endtask

  task automatic run_one(input logic [2:0] r, input int ech, input int ef, input int eerr,
                         input int elat, input string nm);
    int rc, c;
    @(posedge clk); #1;
    req = r; rc = cyc;
    wait_vld(c);
    chk({nm, "_lat"}, c - rc, elat);
    chk({nm, "_ch"}, int'(bus.res_ch), ech);
    chk({nm, "_f"}, int'(bus.res_f), ef);
    chk({nm, "_err"}, int'(bus.res_err), eerr);
    @(posedge clk); #1;
    req = 3'b000;
    repeat (2) @(posedge clk);
  endtask

  int rr_ch [4] = '{0, 1, 2, 0};
  int rr_f  [4] = '{1, 0, 0, 1};

  initial begin
    int rc, c;
    bus.res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_eng_rst_n", int'(bus.eng_rst_n), 0);
    chk("rst_eng_a", int'(bus.eng_a), 0);
    chk("rst_res_vld", int'(bus.res_vld), 0);
    chk("rst_res_ch", int'(bus.res_ch), 0);
    chk("rst_res_f", int'(bus.res_f), 0);
    chk("rst_res_err", int'(bus.res_err), 0);
    chk("rst_hit", int'(hit_cnt), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // All three requesting: ch0 all-8, ch1 all-0, ch2 alternating
    pat = '{1, 0, 2};
    @(posedge clk); #1;
    req = 3'b111; rc = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_vld(c);
      if (i == 0) chk("rr_lat0", c - rc, 261);
      chk("rr_ch", int'(bus.res_ch), rr_ch[i]);
      chk("rr_f", int'(bus.res_f), rr_f[i]);
      @(posedge clk); #1;
      if (i == 3) req = 3'b000;
    end
    repeat (2) @(posedge clk);

    run_one(3'b001, 0, 1, 0, 261, "single");
    chk("model_lat", m_rep_cyc - m_arb_cyc, 260);

    mode = 1;
    run_one(3'b010, 1, 0, 1, 276, "timeout");
    mode = 0;
    pat[2] = 1;
    run_one(3'b100, 2, 1, 0, 261, "after_tmo");

    dly = 15;
    run_one(3'b001, 0, 1, 0, 276, "vld_at_tmo");
    dly = -1;
    run_one(3'b001, 0, 1, 0, 260, "vld_last_run");
    dly = 0;

    mode = 2;
    run_one(3'b010, 1, 0, 0, 261, "spurious");
    mode = 0;

    // Consumer stall: result and grant must hold
    bus.res_rdy = 1'b0;
    @(posedge clk); #1;
    req = 3'b100;
    wait_vld(c);
    @(posedge clk); #1;
    req = 3'b000;
    repeat (20) @(negedge clk);
    chk("stall_vld", int'(bus.res_vld), 1);
    chk("stall_ch", int'(bus.res_ch), 2);
    chk("stall_f", int'(bus.res_f), 1);
    chk("stall_gnt", int'(gnt), 4);
    @(posedge clk); #1;
    bus.res_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_gnt", int'(gnt), 0);
    chk("post_hs_vld", int'(bus.res_vld), 0);
    repeat (2) @(posedge clk);

    // Reset in the middle of the window, at RUN cnt=100
    @(posedge clk); #1;
    req = 3'b001; rc = cyc;
    while (cyc < rc + 104) begin
      @(posedge clk); #1;
    end
    chk("mid_eng_a", int'(bus.eng_a), 8);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_eng_rst_n", int'(bus.eng_rst_n), 0);
    chk("arst_eng_a", int'(bus.eng_a), 0);
    chk("arst_res_vld", int'(bus.res_vld), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rc = cyc;
    wait_vld(c);
    chk("restart_lat", c - rc, 261);
    chk("restart_ch", int'(bus.res_ch), 0);
    chk("restart_f", int'(bus.res_f), 1);
    @(posedge clk); #1;
    req = 3'b000;
    repeat (2) @(posedge clk);

`ifdef RC_STAT_SCHED_HIT_CNT_EN
    pat[1] = 1;
    for (int i = 0; i < 258; i++) run_one(3'b010, 1, 1, 0, 261, "hit");
    @(negedge clk);
    chk("hit_sat_ch1", int'(hit_cnt[15:8]), 255);
`else
    @(negedge clk);
    chk("hit_tied", int'(hit_cnt), 0);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
